// File: rtl/dds_pkg.sv
// Shared types and widths for the DDS sweep controller and its step datapath.
package dds_pkg;

  localparam int FW_W    = 32;
  localparam int PW_W    = 12;
  localparam int WAVE_W  = 2;
  localparam int DWELL_W = 24;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_REPEAT = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_FIXED  = 2'd3
  } mode_t;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

endpackage

// File: rtl/dds_sweep_step.sv
// Next-word arithmetic for the sweep: one step toward limit, clamped so it never wraps or overshoots.
module dds_sweep_step import dds_pkg::*; #(
  parameter int W = FW_W
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  input  logic         dir,
  output logic [W-1:0] next,
  output logic         hit_limit
);

  logic [W:0] sum;
  logic [W:0] diff;

  // One extra bit exposes the carry/borrow so an overflowing step clamps instead of wrapping.
  always_comb begin
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    next = cur;
    if (dir) begin
      if (sum > {1'b0, limit}) next = limit;
      else                     next = sum[W-1:0];
    end else begin
      if (diff[W] || (diff[W-1:0] < limit)) next = limit;
      else                                   next = diff[W-1:0];
    end
    hit_limit = (next == limit);
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep controller feeding the DDS core (single/repeat/triangle/fixed tone).
// Build option SWEEP_PHASE_CONT_EN: set_flag only on sweep launch, giving phase-continuous steps.
module dds_sweep_ctrl #(
  parameter int FW_W    = dds_pkg::FW_W,
  parameter int PW_W    = dds_pkg::PW_W,
  parameter int DWELL_W = dds_pkg::DWELL_W
) (
  input  logic               clk_dds,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FW_W-1:0]    cfg_start,
  input  logic [FW_W-1:0]    cfg_stop,
  input  logic [FW_W-1:0]    cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic [PW_W-1:0]    cfg_p_word,
  input  logic [1:0]         cfg_wave,
  input  logic               start,
  input  logic               abort,
  output logic [FW_W-1:0]    f_word,
  output logic [PW_W-1:0]    p_word,
  output logic [1:0]         wave_type,
  output logic               set_flag,
  output logic               dds_en,
  output logic               busy,
  output logic               done
);
  import dds_pkg::*;

`ifdef SWEEP_PHASE_CONT_EN
  localparam logic UPD_FLAG = 1'b0;
`else
  localparam logic UPD_FLAG = 1'b1;
`endif

  logic [FW_W-1:0]    sh_start, sh_stop, sh_step;
  logic [DWELL_W-1:0] sh_dwell;
  mode_t              sh_mode;
  logic [PW_W-1:0]    sh_pw;
  logic [WAVE_W-1:0]  sh_wave;

  logic [1:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic               dir;
  logic               end_r;
  logic               pend;

  logic               dir0, at_end, eff_dir, go, hit;
  logic [FW_W-1:0]    eff_lim, nxt;
  logic [DWELL_W-1:0] dwell_ld;

  assign dir0     = (sh_start <= sh_stop);
  assign dwell_ld = (sh_dwell == '0) ? '0 : sh_dwell - 1'b1;
  // end_r remembers that the word now on f_word is the active endpoint.
  assign at_end   = end_r || (sh_step == '0);
  assign eff_dir  = (at_end && sh_mode == MODE_TRI) ? ~dir : dir;
  assign eff_lim  = (eff_dir == dir0) ? sh_stop : sh_start;
  // A config capture in the same cycle as start postpones the launch by one cycle via pend.
  assign go       = !abort && (((state == IDLE) && !cfg_valid && (start || pend)) ||
                               ((state == HOLD) && start));

  dds_sweep_step #(.W(FW_W)) u_step (
    .cur       (f_word),
    .step      (sh_step),
    .limit     (eff_lim),
    .dir       (eff_dir),
    .next      (nxt),
    .hit_limit (hit)
  );

  always_ff @(posedge clk_dds) begin
    if (rst) begin
      state     <= IDLE;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      set_flag  <= 1'b0;
      dds_en    <= 1'b0;
      f_word    <= '0;
      p_word    <= '0;
      wave_type <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      end_r     <= 1'b0;
      pend      <= 1'b0;
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_step   <= '0;
      sh_dwell  <= '0;
      sh_mode   <= MODE_SINGLE;
      sh_pw     <= '0;
      sh_wave   <= '0;
    end else begin
      set_flag <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        cfg_ready <= 1'b1;
        busy      <= 1'b0;
        dds_en    <= 1'b0;
        pend      <= 1'b0;
      end else if (go) begin
        state     <= (sh_mode == MODE_FIXED) ? HOLD : RUN;
        busy      <= (sh_mode != MODE_FIXED);
        cfg_ready <= 1'b0;
        f_word    <= sh_start;
        p_word    <= sh_pw;
        wave_type <= sh_wave;
        dds_en    <= 1'b1;
        set_flag  <= 1'b1;
        cnt       <= dwell_ld;
        dir       <= dir0;
        end_r     <= (sh_start == sh_stop);
        pend      <= 1'b0;
      end else if (state == IDLE) begin
        if (cfg_valid) begin
          sh_start <= cfg_start;
          sh_stop  <= cfg_stop;
          sh_step  <= cfg_step;
          sh_dwell <= cfg_dwell;
          sh_mode  <= mode_t'(cfg_mode);
          sh_pw    <= cfg_p_word;
          sh_wave  <= cfg_wave;
          pend     <= start;
        end
      end else if (state == RUN) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          cnt <= dwell_ld;
          if (at_end && sh_mode == MODE_SINGLE) begin
            state <= HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (at_end && sh_mode == MODE_REPEAT) begin
            f_word   <= sh_start;
            end_r    <= (sh_start == sh_stop);
            set_flag <= UPD_FLAG;
          end else begin
            f_word   <= nxt;
            end_r    <= hit;
            set_flag <= UPD_FLAG;
            if (at_end) dir <= ~dir;
          end
        end
      end
    end
  end

endmodule
